// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: opcode encodings, FSM state
// type and small opcode-classification helpers used by the control path.
// Ports: none (package).
package mau_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_LW  = 4'd0;
  localparam logic [OP_W-1:0] OP_LH  = 4'd1;
  localparam logic [OP_W-1:0] OP_LHU = 4'd2;
  localparam logic [OP_W-1:0] OP_LB  = 4'd3;
  localparam logic [OP_W-1:0] OP_LBU = 4'd4;
  localparam logic [OP_W-1:0] OP_LWL = 4'd5;
  localparam logic [OP_W-1:0] OP_LWR = 4'd6;
  localparam logic [OP_W-1:0] OP_SW  = 4'd7;
  localparam logic [OP_W-1:0] OP_SH  = 4'd8;
  localparam logic [OP_W-1:0] OP_SB  = 4'd9;
  localparam logic [OP_W-1:0] OP_SWL = 4'd10;
  localparam logic [OP_W-1:0] OP_SWR = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op == OP_LW)  || (op == OP_LH)  || (op == OP_LHU) ||
           (op == OP_LB)  || (op == OP_LBU) || (op == OP_LWL) ||
           (op == OP_LWR);
  endfunction

  // Stores that must read the old word before writing the merged one.
  function automatic logic is_partial_store(input logic [OP_W-1:0] op);
    return (op == OP_SH) || (op == OP_SB) || (op == OP_SWL) || (op == OP_SWR);
  endfunction

  function automatic logic is_valid_op(input logic [OP_W-1:0] op);
    return is_load(op) || is_partial_store(op) || (op == OP_SW);
  endfunction

  // Word ops need a 4-byte boundary, halfword ops a 2-byte boundary;
  // byte and LWL/LWR/SWL/SWR ops accept any byte offset.
  function automatic logic is_misaligned(input logic [OP_W-1:0] op,
                                         input logic [1:0]      k);
    logic mis;
    mis = 1'b0;
    if ((op == OP_LW) || (op == OP_SW)) begin
      mis = (k != 2'd0);
    end else if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) begin
      mis = k[0];
    end
    return mis;
  endfunction

endpackage

// File: rtl/mau_lane.sv
// Byte-lane steering for the memory access unit (combinational only).
// Ports: op_i/k_i select the operation and byte offset; rd_word_i is the word
// read from memory, wdata_i the store data / old rt. load_data_o is the
// formatted load result, store_word_o the full word to write back.
module mau_lane
  import mau_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  input  logic [1:0]      k_i,
  input  logic [31:0]     rd_word_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     load_data_o,
  output logic [31:0]     store_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lanes: byte k lives at bit 8k, halfword at bit 16*addr[1].
  assign byte_sel = rd_word_i[{k_i, 3'b000} +: 8];
  assign half_sel = rd_word_i[{k_i[1], 4'b0000} +: 16];

  always_comb begin
    load_data_o = 32'd0;
    case (op_i)
      OP_LW:  load_data_o = rd_word_i;
      OP_LH:  load_data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU: load_data_o = {16'd0, half_sel};
      OP_LB:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: load_data_o = {24'd0, byte_sel};
      // LWL fills rt from the top with memory bytes k..0; low rt bytes survive.
      OP_LWL: begin
        case (k_i)
          2'd0:    load_data_o = {rd_word_i[7:0],  wdata_i[23:0]};
          2'd1:    load_data_o = {rd_word_i[15:0], wdata_i[15:0]};
          2'd2:    load_data_o = {rd_word_i[23:0], wdata_i[7:0]};
          default: load_data_o = rd_word_i;
        endcase
      end
      // LWR fills rt from the bottom with memory bytes 3..k; high rt bytes survive.
      OP_LWR: begin
        case (k_i)
          2'd0:    load_data_o = rd_word_i;
          2'd1:    load_data_o = {wdata_i[31:24], rd_word_i[31:8]};
          2'd2:    load_data_o = {wdata_i[31:16], rd_word_i[31:16]};
          default: load_data_o = {wdata_i[31:8],  rd_word_i[31:24]};
        endcase
      end
      default: load_data_o = 32'd0;
    endcase
  end

  always_comb begin
    store_word_o = wdata_i;
    case (op_i)
      OP_SB: begin
        store_word_o = rd_word_i;
        store_word_o[{k_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      OP_SH: begin
        store_word_o = rd_word_i;
        store_word_o[{k_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      // SWL writes the top bytes of rt into memory bytes k..0.
      OP_SWL: begin
        case (k_i)
          2'd0:    store_word_o = {rd_word_i[31:8],  wdata_i[31:24]};
          2'd1:    store_word_o = {rd_word_i[31:16], wdata_i[31:16]};
          2'd2:    store_word_o = {rd_word_i[31:24], wdata_i[31:8]};
          default: store_word_o = wdata_i;
        endcase
      end
      // SWR writes the bottom bytes of rt into memory bytes 3..k.
      OP_SWR: begin
        case (k_i)
          2'd0:    store_word_o = wdata_i;
          2'd1:    store_word_o = {wdata_i[23:0], rd_word_i[7:0]};
          2'd2:    store_word_o = {wdata_i[15:0], rd_word_i[15:0]};
          default: store_word_o = {wdata_i[7:0],  rd_word_i[23:0]};
        endcase
      end
      default: store_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store initiator for the word-organised data memory. Holds one
// request at a time, checks alignment/range, issues word-aligned read and
// full-word write cycles (sub-word stores via read-modify-write).
// Ports: req_* request handshake from the pipeline; resp_* one-cycle result
// pulse (no backpressure); mem_* combinational word interface to dm.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DM_WORDS = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic            resp_valid,
  output logic [31:0]     resp_rdata,
  output logic            resp_err,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic            mem_we,
  output logic            mem_re,
  input  logic [31:0]     mem_rdata
);

  // One bit wider than the address so DM_WORDS*4 == 2^32 cannot wrap.
  localparam logic [32:0] DM_BYTES = 33'(DM_WORDS) << 2;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rd_word_q, rd_word_d;
  logic            err_q, err_d;

  logic        accept;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic [31:0] word_addr;

  // Unknown opcodes are reported as errors rather than silently dropped.
  assign req_err = !is_valid_op(req_op) ||
                   is_misaligned(req_op, req_addr[1:0]) ||
                   ({1'b0, req_addr} >= DM_BYTES);

  assign accept    = req_valid && req_ready;
  assign word_addr = {addr_q[31:2], 2'b00};

  mau_lane u_lane (
    .op_i         (op_q),
    .k_i          (addr_q[1:0]),
    .rd_word_i    (rd_word_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LW;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rd_word_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_word_q <= rd_word_d;
      err_q     <= err_d;
    end
  end

  // Request fields are captured only on accept, so later input changes are
  // ignored for the rest of the transaction.
  always_comb begin
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rd_word_d = rd_word_q;
    if (accept) begin
      op_d    = req_op;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      err_d   = req_err;
    end
    if (state_q == ST_RD) begin
      rd_word_d = mem_rdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err) begin
            state_d = ST_RESP;
          end else if (req_op == OP_SW) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        mem_re   = 1'b1;
        mem_addr = word_addr;
        state_d  = is_partial_store(op_q) ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        mem_we    = 1'b1;
        mem_addr  = word_addr;
        mem_wdata = store_word;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && is_load(op_q)) begin
          resp_rdata = load_data;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // While reset is high the unit is quiescent: in particular a store caught
    // in its write cycle must not reach memory.
    if (reset) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = 32'd0;
      resp_err   = 1'b0;
      mem_addr   = 32'd0;
      mem_wdata  = 32'd0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam int DM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  int n_chk = 0;
  int n_pass = 0;

  mem_access_unit #(.DM_WORDS(DM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on posedge.
  logic [31:0] dm [0:DM_WORDS-1];
  assign mem_rdata = dm[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) dm[mem_addr[11:2]] <= mem_wdata;

  // Reference model state: memory contents as the spec says they should be.
  logic [31:0] ref_mem [0:DM_WORDS-1];

  // Byte-level reference: computes result, error, latency and written word.
  task automatic model(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] rt, output int lat,
                       output logic [31:0] rd, output logic err,
                       output logic wr, output logic [31:0] wword);
    logic [7:0] w [4];
    logic [7:0] r [4];
    logic [7:0] o [4];
    logic [31:0] word;
    int k;
    k = int'(addr[1:0]);
    err = (addr >= 32'(DM_WORDS * 4)) ||
          ((op == OP_LW || op == OP_SW) && k != 0) ||
          ((op == OP_LH || op == OP_LHU || op == OP_SH) && (k % 2) != 0);
    rd = 32'd0; wr = 1'b0; wword = 32'd0;
    if (err) begin
      lat = 1;
      return;
    end
    word = ref_mem[addr[11:2]];
    for (int i = 0; i < 4; i++) begin
      w[i] = word[8*i +: 8];
      r[i] = rt[8*i +: 8];
      o[i] = w[i];
    end
    lat = (op == OP_SB || op == OP_SH || op == OP_SWL || op == OP_SWR) ? 3 : 2;
    case (op)
      OP_LW:  rd = word;
      OP_LB:  rd = {{24{w[k][7]}}, w[k]};
      OP_LBU: rd = {24'd0, w[k]};
      OP_LH:  rd = {{16{w[k+1][7]}}, w[k+1], w[k]};
      OP_LHU: rd = {16'd0, w[k+1], w[k]};
      OP_LWL: for (int i = 0; i < 4; i++)
                rd[8*i +: 8] = (i >= 3 - k) ? w[i-(3-k)] : r[i];
      OP_LWR: for (int i = 0; i < 4; i++)
                rd[8*i +: 8] = (i <= 3 - k) ? w[i+k] : r[i];
      OP_SW:  for (int i = 0; i < 4; i++) o[i] = r[i];
      OP_SB:  o[k] = r[0];
      OP_SH:  begin o[k] = r[0]; o[k+1] = r[1]; end
      OP_SWL: for (int j = 0; j <= k; j++) o[j] = r[j+3-k];
      OP_SWR: for (int j = k; j < 4; j++) o[j] = r[j-k];
      default: ;
    endcase
    if (!is_load(op)) begin
      wr = 1'b1;
      for (int i = 0; i < 4; i++) wword[8*i +: 8] = o[i];
      ref_mem[addr[11:2]] = wword;
    end
  endtask

  // Issue one request from an IDLE negedge; observe until the response and
  // return at the negedge of the following (IDLE) cycle.
  task automatic do_req(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat,
                        output logic [31:0] rd, output logic err,
                        output int n_we, output int n_re,
                        output logic [31:0] we_addr, output logic [31:0] we_data,
                        output int we_cyc);
    req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = -1; rd = 32'hx; err = 1'bx; n_we = 0; n_re = 0;
    we_addr = 32'hx; we_data = 32'hx; we_cyc = -1;
    for (int c = 1; c <= 8; c++) begin
      if (mem_we) begin n_we++; we_addr = mem_addr; we_data = mem_wdata; we_cyc = c; end
      if (mem_re) n_re++;
      if (resp_valid) begin lat = c; rd = resp_rdata; err = resp_err; end
      @(posedge clk); @(negedge clk);
      if (lat >= 0) break;
    end
  endtask

  // Scratch variables for tests.
  int lat, n_we, n_re, we_cyc, e_lat;
  logic [31:0] rd, we_addr, we_data, e_rd, e_w;
  logic err, e_err, e_wr;

  task automatic run(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    model(op, addr, wd, e_lat, e_rd, e_err, e_wr, e_w);
    do_req(op, addr, wd, lat, rd, err, n_we, n_re, we_addr, we_data, we_cyc);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({req_ready, resp_valid, resp_err, mem_we, mem_re} !== 5'b0)
      $display("FAIL reset_ctl: got %b want 00000", {req_ready, resp_valid, resp_err, mem_we, mem_re});
    else n_pass++;
    n_chk++;
    if ({mem_addr, resp_rdata} !== 64'd0)
      $display("FAIL reset_data: got addr=%h rdata=%h want 0", mem_addr, resp_rdata);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_chk++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_sw_lw();
    run(OP_SW, 32'h10, 32'hDEADBEEF);
    n_chk++;
    if (lat !== 2 || n_we !== 1 || we_cyc !== 1 || we_addr !== 32'h10 || we_data !== 32'hDEADBEEF)
      $display("FAIL sw: got lat=%0d we=%0d cyc=%0d addr=%h data=%h want 2 1 1 00000010 deadbeef",
               lat, n_we, we_cyc, we_addr, we_data);
    else n_pass++;
    n_chk++;
    if (rd !== 32'd0 || err !== 1'b0 || n_re !== 0)
      $display("FAIL sw_resp: got rdata=%h err=%b re=%0d want 0 0 0", rd, err, n_re);
    else n_pass++;
    run(OP_LW, 32'h10, 32'h0);
    n_chk++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || n_re !== 1 || n_we !== 0)
      $display("FAIL lw: got lat=%0d rdata=%h re=%0d we=%0d want 2 deadbeef 1 0", lat, rd, n_re, n_we);
    else n_pass++;
  endtask

  task automatic test_sb_loads();
    run(OP_SW, 32'h20, 32'h11223344);
    run(OP_SB, 32'h21, 32'h000000AA);
    n_chk++;
    if (lat !== 3 || n_re !== 1 || we_cyc !== 2 || we_addr !== 32'h20 || we_data !== 32'h1122AA44)
      $display("FAIL sb: got lat=%0d re=%0d cyc=%0d addr=%h data=%h want 3 1 2 00000020 1122aa44",
               lat, n_re, we_cyc, we_addr, we_data);
    else n_pass++;
    run(OP_LB, 32'h21, 32'h0);
    n_chk++;
    if (rd !== 32'hFFFFFFAA) $display("FAIL lb: got %h want ffffffaa", rd);
    else n_pass++;
    run(OP_LBU, 32'h21, 32'h0);
    n_chk++;
    if (rd !== 32'h000000AA) $display("FAIL lbu: got %h want 000000aa", rd);
    else n_pass++;
  endtask

  task automatic test_unaligned_ops();
    run(OP_SW, 32'h30, 32'h11223344);
    run(OP_SWL, 32'h31, 32'hAABBCCDD);
    n_chk++;
    if (we_data !== 32'h1122AABB || lat !== 3) $display("FAIL swl: got %h lat=%0d want 1122aabb 3", we_data, lat);
    else n_pass++;
    run(OP_SW, 32'h30, 32'h11223344);
    run(OP_SWR, 32'h32, 32'hAABBCCDD);
    n_chk++;
    if (we_data !== 32'hCCDD3344) $display("FAIL swr: got %h want ccdd3344", we_data);
    else n_pass++;
    run(OP_SW, 32'h30, 32'h11223344);
    run(OP_LWL, 32'h31, 32'hAABBCCDD);
    n_chk++;
    if (rd !== 32'h3344CCDD || lat !== 2) $display("FAIL lwl: got %h lat=%0d want 3344ccdd 2", rd, lat);
    else n_pass++;
    run(OP_LWR, 32'h32, 32'hAABBCCDD);
    n_chk++;
    if (rd !== 32'hAABB1122) $display("FAIL lwr: got %h want aabb1122", rd);
    else n_pass++;
  endtask

  task automatic test_errors();
    run(OP_LH, 32'h41, 32'h12345678);
    n_chk++;
    if (lat !== 1 || err !== 1'b1 || rd !== 32'd0 || n_re !== 0 || n_we !== 0)
      $display("FAIL err_lh: got lat=%0d err=%b rdata=%h re=%0d we=%0d want 1 1 0 0 0",
               lat, err, rd, n_re, n_we);
    else n_pass++;
    run(OP_SW, 32'h1000, 32'hCAFEF00D);
    n_chk++;
    if (lat !== 1 || err !== 1'b1 || n_we !== 0)
      $display("FAIL err_range: got lat=%0d err=%b we=%0d want 1 1 0", lat, err, n_we);
    else n_pass++;
  endtask

  task automatic test_reset_mid_store();
    int resp_seen;
    run(OP_SW, 32'h50, 32'h01020304);
    req_op = OP_SB; req_addr = 32'h52; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    n_chk++;
    if (mem_we !== 1'b1) $display("FAIL rst_wr_state: got mem_we=%b want 1", mem_we);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_chk++;
    if (mem_we !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL rst_gate: got mem_we=%b resp_valid=%b want 0 0", mem_we, resp_valid);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_chk++;
    if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", req_ready);
    else n_pass++;
    resp_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    n_chk++;
    if (resp_seen !== 0) $display("FAIL rst_noresp: got %0d responses want 0", resp_seen);
    else n_pass++;
    n_chk++;
    if (dm[20] !== 32'h01020304) $display("FAIL rst_nowrite: got %h want 01020304", dm[20]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc, r1, r2, busy_ready;
    logic accepting;
    logic [31:0] d2, exp_d2;
    run(OP_SW, 32'h60, 32'hA0B0C0D0);
    model(OP_SB, 32'h63, 32'h5E, e_lat, e_rd, e_err, e_wr, e_w);
    model(OP_LW, 32'h60, 32'h0, e_lat, exp_d2, e_err, e_wr, e_w);
    req_op = OP_SB; req_addr = 32'h63; req_wdata = 32'h5E; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_op = OP_LW; req_addr = 32'h60; req_wdata = 32'h0;
    acc = -1; r1 = -1; r2 = -1; busy_ready = 0; d2 = 32'hx;
    for (int c = 1; c <= 10; c++) begin
      if (resp_valid) begin
        if (r1 < 0) r1 = c;
        else if (r2 < 0) begin r2 = c; d2 = resp_rdata; end
      end
      if (c <= 3 && req_ready) busy_ready++;
      accepting = req_valid && req_ready;
      @(posedge clk); @(negedge clk);
      if (accepting && acc < 0) begin acc = c; req_valid = 1'b0; end
    end
    req_valid = 1'b0;
    n_chk++;
    if (busy_ready !== 0) $display("FAIL b2b_busy: got ready high %0d cycles want 0", busy_ready);
    else n_pass++;
    n_chk++;
    if (r1 !== 3 || acc !== 4 || r2 !== 6)
      $display("FAIL b2b_timing: got resp1=%0d accept=%0d resp2=%0d want 3 4 6", r1, acc, r2);
    else n_pass++;
    n_chk++;
    if (d2 !== exp_d2 || d2 !== 32'h5EB0C0D0) $display("FAIL b2b_data: got %h want 5eb0c0d0", d2);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [31:0] addr;
    for (int i = 0; i < 16; i++) run(OP_SW, 32'h100 + 32'(4*i), $urandom);
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 7) == 0) addr = 32'h1000 + 32'($urandom_range(0, 255)) + ($urandom & 32'hFFFF0000);
      else addr = 32'h100 + 32'($urandom_range(0, 63));
      run(op, addr, $urandom);
      n_chk++;
      if (lat !== e_lat || err !== e_err || rd !== e_rd)
        $display("FAIL rnd_resp[%0d] op=%0d addr=%h: got lat=%0d err=%b rdata=%h want %0d %b %h",
                 n, op, addr, lat, err, rd, e_lat, e_err, e_rd);
      else n_pass++;
      n_chk++;
      if (n_we !== (e_wr ? 1 : 0))
        $display("FAIL rnd_wecount[%0d]: got %0d want %0d", n, n_we, e_wr ? 1 : 0);
      else n_pass++;
      if (e_wr) begin
        n_chk++;
        if (we_data !== e_w || we_addr !== {addr[31:2], 2'b00})
          $display("FAIL rnd_wr[%0d] op=%0d: got %h@%h want %h@%h", n, op, we_data, we_addr, e_w, {addr[31:2], 2'b00});
        else n_pass++;
      end
    end
    for (int i = 64; i < 80; i++) begin
      n_chk++;
      if (dm[i] !== ref_mem[i]) $display("FAIL rnd_mem[%0d]: got %h want %h", i, dm[i], ref_mem[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_sb_loads();
    test_unaligned_ops();
    test_errors();
    test_reset_mid_store();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
